// File: rtl/bcd_sevenseg_converter_pkg.sv
// Shared constants for the BCD to 7-segment path: segment patterns and FSM encodings.
// Pure declarations, no logic or latency.
// Segment patterns are active low with bit order {dp,g,f,e,d,c,b,a}.
package bcd_sevenseg_converter_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  localparam int DP_BIT = 7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

endpackage

// File: rtl/bcd_sevenseg_converter_enc.sv
// Single BCD digit to active-low 7-segment pattern, dp left off.
// Combinational, zero latency; no handshake.
// Codes above 9 show blank; the converter never produces them.
module sevenseg_digit_enc
  import bcd_sevenseg_converter_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] seg
);

  // Digit lookup
  always_comb begin
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_sevenseg_converter.sv
// Binary to NDIG-digit 7-segment converter using sequential double-dabble.
// Latency: accept edge N -> out_valid pulse visible after edge N+WIDTH+1.
// in_ready high only in IDLE; in_valid while busy is ignored, nothing queued.
module bcd_sevenseg_converter
  import bcd_sevenseg_converter_pkg::*;
#(
  parameter int               WIDTH    = 6,
  parameter int               NDIG     = 2,
  parameter bit               BLANK_LZ = 1'b0,
  parameter logic [NDIG-1:0]  DP_MASK  = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_value,
  output logic                out_valid,
  output logic [8*NDIG-1:0]   seg_out,
  output logic                overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]          state;
  logic [WIDTH-1:0]    shreg;
  logic [4*NDIG-1:0]   bcd;
  logic [4*NDIG-1:0]   bcd_adj;
  logic                ovf_sticky;
  logic [CNT_W-1:0]    cnt;
  logic [8*NDIG-1:0]   enc_all;
  logic [8*NDIG-1:0]   seg_next;
  logic                zero_above;
  logic                bcd_ok;

  assign in_ready = (state == ST_IDLE);

  // Add-3 correction on every nibble that is 5 or more, 4-bit modulo
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NDIG; g++) begin : g_enc
      sevenseg_digit_enc u_enc (
        .digit (bcd[4*g +: 4]),
        .seg   (enc_all[8*g +: 8])
      );
    end
  endgenerate

  // Final display pattern: dash on overflow, optional leading-zero blanking, then dp overlay
  always_comb begin
    seg_next   = enc_all;
    zero_above = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      if (ovf_sticky) begin
        seg_next[8*i +: 8] = SEG_DASH;
      end else if (BLANK_LZ && (i > 0) && zero_above && (bcd[4*i +: 4] == 4'd0)) begin
        seg_next[8*i +: 8] = SEG_BLANK;
      end
      zero_above = zero_above && (bcd[4*i +: 4] == 4'd0);
      if (DP_MASK[i]) seg_next[8*i + DP_BIT] = 1'b0;
    end
  end

  // Conversion FSM, shift/BCD datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bcd        <= '0;
      ovf_sticky <= 1'b0;
      cnt        <= '0;
      seg_out    <= '1;
      overflow   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            shreg      <= in_value;
            bcd        <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= CNT_W'(WIDTH - 1);
            state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd        <= {bcd_adj[4*NDIG-2:0], shreg[WIDTH-1]};
          shreg      <= shreg << 1;
          ovf_sticky <= ovf_sticky | bcd_adj[4*NDIG-1];
          if (cnt == '0) state <= ST_LOAD;
          else           cnt   <= cnt - 1'b1;
        end
        ST_LOAD: begin
          seg_out   <= seg_next;
          overflow  <= ovf_sticky;
          out_valid <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Every nibble must be a legal decimal digit when results are loaded
  always_comb begin
    bcd_ok = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd[4*i +: 4] > 4'd9) bcd_ok = 1'b0;
    end
  end

  bcd_digit_range : assert property (@(posedge clk) disable iff (!rst_n)
                                     (state == ST_LOAD) |-> bcd_ok);

endmodule

// File: tb/tb_bcd_sevenseg_converter.sv
// Scoreboard bench for bcd_sevenseg_converter across five parameter sets.
module tb_bcd_sevenseg_converter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int WS  [5] = '{6, 8, 14, 6, 1};
  localparam int NS  [5] = '{2, 2, 4, 2, 1};
  localparam int BL  [5] = '{0, 0, 1, 0, 0};
  localparam int DPS [5] = '{0, 0, 0, 2, 0};

  logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  typedef struct {
    logic [31:0] seg;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb [5][$];

  logic        vld [5];
  logic [31:0] val [5];
  logic        rdy [5];
  logic        ov  [5];
  logic        ovf [5];
  logic [31:0] sg  [5];
  logic [15:0] seg_a, seg_b, seg_d;
  logic [31:0] seg_c;
  logic [7:0]  seg_e;

  assign sg[0] = {16'h0, seg_a};
  assign sg[1] = {16'h0, seg_b};
  assign sg[2] = seg_c;
  assign sg[3] = {16'h0, seg_d};
  assign sg[4] = {24'h0, seg_e};

  bcd_sevenseg_converter #(.WIDTH(6), .NDIG(2), .BLANK_LZ(1'b0), .DP_MASK(2'b00)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]), .in_value(val[0][5:0]),
    .out_valid(ov[0]), .seg_out(seg_a), .overflow(ovf[0]));
  bcd_sevenseg_converter #(.WIDTH(8), .NDIG(2), .BLANK_LZ(1'b0), .DP_MASK(2'b00)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]), .in_value(val[1][7:0]),
    .out_valid(ov[1]), .seg_out(seg_b), .overflow(ovf[1]));
  bcd_sevenseg_converter #(.WIDTH(14), .NDIG(4), .BLANK_LZ(1'b1), .DP_MASK(4'b0000)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(rdy[2]), .in_value(val[2][13:0]),
    .out_valid(ov[2]), .seg_out(seg_c), .overflow(ovf[2]));
  bcd_sevenseg_converter #(.WIDTH(6), .NDIG(2), .BLANK_LZ(1'b0), .DP_MASK(2'b10)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[3]), .in_ready(rdy[3]), .in_value(val[3][5:0]),
    .out_valid(ov[3]), .seg_out(seg_d), .overflow(ovf[3]));
  bcd_sevenseg_converter #(.WIDTH(1), .NDIG(1), .BLANK_LZ(1'b0), .DP_MASK(1'b0)) u_e (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[4]), .in_ready(rdy[4]), .in_value(val[4][0:0]),
    .out_valid(ov[4]), .seg_out(seg_e), .overflow(ovf[4]));

  int total = 0;
  int bad   = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result from plain decimal arithmetic
  function automatic exp_t model(int d, int v);
    exp_t e;
    int   p;
    int   lim;
    logic [7:0] enc;
    lim = 1;
    for (int i = 0; i < NS[d]; i++) lim *= 10;
    e.ovf = (v >= lim);
    e.seg = '0;
    e.due = 0;
    p = 1;
    for (int i = 0; i < NS[d]; i++) begin
      enc = seg_tbl[(v / p) % 10];
      if (e.ovf) enc = 8'hBF;
      else if (BL[d] != 0 && i > 0 && v < p) enc = 8'hFF;
      if (((DPS[d] >> i) & 1) != 0) enc[7] = 1'b0;
      e.seg[8*i +: 8] = enc;
      p *= 10;
    end
    return e;
  endfunction

  // Pop and compare every result pulse, including its arrival cycle
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < 5; i++) begin
        if (ov[i]) begin
          if (sb[i].size() == 0) begin
            check($sformatf("spurious_pulse_dut%0d", i), 32'd1, 32'd0);
          end else begin
            e = sb[i].pop_front();
            check($sformatf("seg_dut%0d", i), sg[i], e.seg);
            check($sformatf("ovf_dut%0d", i), {31'd0, ovf[i]}, {31'd0, e.ovf});
            check($sformatf("latency_dut%0d", i), cyc, e.due);
          end
        end
      end
    end
  end

  task automatic send(int d, int v);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    vld[d] = 1'b1;
    val[d] = v;
    while (!rdy[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[d]) begin
      check($sformatf("ready_timeout_dut%0d", d), 32'd0, 32'd1);
      vld[d] = 1'b0;
      return;
    end
    e = model(d, v);
    e.due = cyc + WS[d] + 2;
    sb[d].push_back(e);
    @(posedge clk);
    #1 vld[d] = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() + sb[4].size()) != 0
           && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", n, (n < 500) ? n : 0);
  endtask

  initial begin
    exp_t e;
    int   n;
    logic [31:0] ones;
    for (int i = 0; i < 5; i++) begin
      vld[i] = 1'b0;
      val[i] = '0;
    end

    // Reset state
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      ones = 32'hFFFF_FFFF >> (32 - 8 * NS[i]);
      check($sformatf("rst_ready_dut%0d", i), {31'd0, rdy[i]}, 32'd1);
      check($sformatf("rst_valid_dut%0d", i), {31'd0, ov[i]}, 32'd0);
      check($sformatf("rst_ovf_dut%0d", i), {31'd0, ovf[i]}, 32'd0);
      check($sformatf("rst_seg_dut%0d", i), sg[i], ones);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(0, 59);
    send(1, 99);
    send(1, 100);
    send(1, 255);
    send(1, 0);
    send(2, 0);
    send(2, 205);
    send(2, 9999);
    send(2, 10000);
    send(2, 16383);
    send(3, 7);
    send(3, 42);
    send(3, 0);
    send(4, 0);
    send(4, 1);
    send(0, 63);
    send(0, 0);
    wait_drain();

    // Busy: in_valid held, value changes to 34 while converting 12
    @(negedge clk);
    vld[0] = 1'b1;
    val[0] = 12;
    check("busy_first_ready", {31'd0, rdy[0]}, 32'd1);
    e = model(0, 12);
    e.due = cyc + WS[0] + 2;
    sb[0].push_back(e);
    @(posedge clk);
    #1 val[0] = 34;
    n = 0;
    @(negedge clk);
    while (!rdy[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy_second_ready", {31'd0, rdy[0]}, 32'd1);
    e = model(0, 34);
    e.due = cyc + WS[0] + 2;
    sb[0].push_back(e);
    @(posedge clk);
    #1 vld[0] = 1'b0;
    wait_drain();

    // Reset in the middle of a conversion
    @(negedge clk);
    vld[0] = 1'b1;
    val[0] = 45;
    @(posedge clk);
    #1 vld[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midshift_busy", {31'd0, rdy[0]}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_ready", {31'd0, rdy[0]}, 32'd1);
    check("abort_valid", {31'd0, ov[0]}, 32'd0);
    check("abort_seg", sg[0], 32'h0000_FFFF);
    check("abort_ovf", {31'd0, ovf[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);

    send(0, 59);
    wait_drain();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) check($sformatf("left_in_queue_dut%0d", i), sb[i].size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
